// File: rtl/mem_read_collector_if.sv
// rtl/mem_read_collector_if.sv - read-request, select, bank-data and read-return bus for mem_read_collector
interface mem_read_collector_if #(
  parameter int DATA_WIDTH   = 8,
  parameter int NB_WRAGENT   = 2,
  parameter int NB_RDAGENT   = 2,
  parameter int SELECT_WIDTH = (NB_WRAGENT == 1) ? 1 : $clog2(NB_WRAGENT)
);
  logic [NB_RDAGENT-1:0]                       rden;
  logic [NB_RDAGENT*SELECT_WIDTH-1:0]          rdselect;
  logic [NB_WRAGENT*NB_RDAGENT*DATA_WIDTH-1:0] bank_rddata;
  logic [NB_RDAGENT*DATA_WIDTH-1:0]            rddata;
  logic [NB_RDAGENT-1:0]                       rdvalid;
  logic [NB_RDAGENT-1:0]                       rderr;

  modport master (
    output rden,
    output rdselect,
    output bank_rddata,
    input  rddata,
    input  rdvalid,
    input  rderr
  );

  modport slave (
    input  rden,
    input  rdselect,
    input  bank_rddata,
    output rddata,
    output rdvalid,
    output rderr
  );
endinterface

// File: rtl/mem_read_collector.sv
// rtl/mem_read_collector.sv - per-read-agent in-flight tracking, select alignment and bank mux with registered return
module mem_read_collector #(
  parameter int DATA_WIDTH     = 8,
  parameter int NB_WRAGENT     = 2,
  parameter int NB_RDAGENT     = 2,
  parameter int SELECT_WIDTH   = (NB_WRAGENT == 1) ? 1 : $clog2(NB_WRAGENT),
  parameter int SELECT_LATENCY = 1,
  parameter int RAM_LATENCY    = 1
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  mem_read_collector_if.slave  bus
);

  // The select arrives SEL_DELAY cycles ahead of the bank data it steers.
  localparam int SEL_DELAY = RAM_LATENCY - SELECT_LATENCY;
  localparam logic [SELECT_WIDTH:0] SEL_LIMIT = (SELECT_WIDTH + 1)'(NB_WRAGENT);

  for (genvar r = 0; r < NB_RDAGENT; r++) begin : g_lane
    logic [RAM_LATENCY-1:0]                   vld_pipe;
    logic                                     vld_last;
    logic [SELECT_WIDTH-1:0]                  sel_in;
    logic [SELECT_WIDTH-1:0]                  sel_aligned;
    logic [NB_WRAGENT-1:0][DATA_WIDTH-1:0]    bank_word;
    logic [DATA_WIDTH-1:0]                    mux_data;
    logic                                     mux_err;
    logic [DATA_WIDTH-1:0]                    rddata_q;
    logic                                     rdvalid_q;
    logic                                     rderr_q;

    assign sel_in   = bus.rdselect[r*SELECT_WIDTH +: SELECT_WIDTH];
    assign vld_last = vld_pipe[RAM_LATENCY-1];

    for (genvar w = 0; w < NB_WRAGENT; w++) begin : g_bank
      assign bank_word[w] = bus.bank_rddata[(w*NB_RDAGENT + r)*DATA_WIDTH +: DATA_WIDTH];
    end

    if (RAM_LATENCY == 1) begin : g_vld_one
      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
          vld_pipe <= '0;
        end else begin
          vld_pipe <= bus.rden[r];
        end
      end
    end else begin : g_vld_multi
      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
          vld_pipe <= '0;
        end else begin
          vld_pipe <= {vld_pipe[RAM_LATENCY-2:0], bus.rden[r]};
        end
      end
    end

    // The select pipe runs unconditionally; only the value lining up with a valid read is used.
    if (SEL_DELAY == 0) begin : g_sel_live
      assign sel_aligned = sel_in;
    end else if (SEL_DELAY == 1) begin : g_sel_one
      logic [SELECT_WIDTH-1:0] sel_pipe;
      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
          sel_pipe <= '0;
        end else begin
          sel_pipe <= sel_in;
        end
      end
      assign sel_aligned = sel_pipe;
    end else begin : g_sel_multi
      logic [SEL_DELAY-1:0][SELECT_WIDTH-1:0] sel_pipe;
      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
          sel_pipe <= '0;
        end else begin
          sel_pipe <= {sel_pipe[SEL_DELAY-2:0], sel_in};
        end
      end
      assign sel_aligned = sel_pipe[SEL_DELAY-1];
    end

    if (NB_WRAGENT == 1) begin : g_mux_single
      always_comb begin
        mux_data = bank_word[0];
        mux_err  = 1'b0;
      end
    end else begin : g_mux_multi
      always_comb begin
        mux_data = '0;
        mux_err  = 1'b0;
        if ({1'b0, sel_aligned} >= SEL_LIMIT) begin
          mux_err = 1'b1;
        end else begin
          mux_data = bank_word[sel_aligned];
        end
      end
    end

    // rddata only moves on a returned read so the last word stays visible across idle cycles.
    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
        rddata_q  <= '0;
        rdvalid_q <= 1'b0;
        rderr_q   <= 1'b0;
      end else begin
        rdvalid_q <= vld_last;
        rderr_q   <= vld_last & mux_err;
        if (vld_last) begin
          rddata_q <= mux_data;
        end
      end
    end

    assign bus.rddata[r*DATA_WIDTH +: DATA_WIDTH] = rddata_q;
    assign bus.rdvalid[r]                         = rdvalid_q;
    assign bus.rderr[r]                           = rderr_q;
  end

endmodule

// File: tb/tb_mem_read_collector.sv
// tb/tb_mem_read_collector.sv - scoreboard bench for two mem_read_collector configurations
module tb_mem_read_collector;
  localparam int DW   = 8;
  localparam int NR   = 2;
  localparam int NWA  = 3;
  localparam int SWA  = 2;
  localparam int RLA  = 3;
  localparam int SLA  = 1;
  localparam int NWB  = 2;
  localparam int SWB  = 1;
  localparam int RLB  = 1;
  localparam int SLB  = 1;
  localparam int NCYC = 2048;

  typedef struct {
    int            due;
    logic [DW-1:0] data;
    logic          err;
  } exp_t;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  int   edge_cnt = 0;
  int   kill_before = 1;
  int   checks = 0;
  int   errors = 0;

  logic [NR-1:0] rden_h [NCYC];
  logic [1:0]    sel_h  [NCYC][NR];
  logic [DW-1:0] bank_h [NCYC][3][NR];
  exp_t          qa [NR][$];
  exp_t          qb [NR][$];
  logic [DW-1:0] last_a [NR];
  logic [DW-1:0] last_b [NR];

  always #5 aclk = ~aclk;
  always @(posedge aclk) edge_cnt <= edge_cnt + 1;

  mem_read_collector_if #(.DATA_WIDTH(DW), .NB_WRAGENT(NWA), .NB_RDAGENT(NR), .SELECT_WIDTH(SWA)) bus_a ();
  mem_read_collector_if #(.DATA_WIDTH(DW), .NB_WRAGENT(NWB), .NB_RDAGENT(NR), .SELECT_WIDTH(SWB)) bus_b ();

  mem_read_collector #(
    .DATA_WIDTH(DW), .NB_WRAGENT(NWA), .NB_RDAGENT(NR), .SELECT_WIDTH(SWA),
    .SELECT_LATENCY(SLA), .RAM_LATENCY(RLA)
  ) dut_a (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus_a)
  );

  mem_read_collector #(
    .DATA_WIDTH(DW), .NB_WRAGENT(NWB), .NB_RDAGENT(NR), .SELECT_WIDTH(SWB),
    .SELECT_LATENCY(SLB), .RAM_LATENCY(RLB)
  ) dut_b (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus_b)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at edge %0d", name, got, exp, edge_cnt);
    end
  endtask

  // Reference: a read sampled at edge ea returns the word of the bank named by the select
  // sampled at edge ea+sl, taken from bank data sampled at edge ea+rl, visible after edge ea+rl.
  function automatic exp_t model(input int nw, input int sw, input int sl, input int rl,
                                 input int ea, input int r);
    exp_t x;
    int   s;
    s = int'(sel_h[ea + sl][r]) % (1 << sw);
    if (nw == 1) s = 0;
    x.due = ea + rl;
    if (s >= nw) begin
      x.data = '0;
      x.err  = 1'b1;
    end else begin
      x.data = bank_h[ea + rl][s][r];
      x.err  = 1'b0;
    end
    return x;
  endfunction

  task automatic step(input logic [NR-1:0] rd, input logic [1:0] s0, input logic [1:0] s1);
    int e;
    int ea;
    @(posedge aclk);
    #1;
    e = edge_cnt + 1;
    if (e >= NCYC) begin
      $display("FAIL history_overflow got %0d expected below %0d", e, NCYC);
      $fatal(1, "history overflow");
    end
    rden_h[e]   = rd;
    sel_h[e][0] = s0;
    sel_h[e][1] = s1;
    for (int w = 0; w < 3; w++)
      for (int r = 0; r < NR; r++)
        bank_h[e][w][r] = DW'($urandom);
    bus_a.rden = rd;
    bus_b.rden = rd;
    for (int r = 0; r < NR; r++) begin
      bus_a.rdselect[r*SWA +: SWA] = sel_h[e][r];
      bus_b.rdselect[r*SWB +: SWB] = sel_h[e][r][0:0];
      for (int w = 0; w < NWA; w++) bus_a.bank_rddata[(w*NR + r)*DW +: DW] = bank_h[e][w][r];
      for (int w = 0; w < NWB; w++) bus_b.bank_rddata[(w*NR + r)*DW +: DW] = bank_h[e][w][r];
    end
    for (int r = 0; r < NR; r++) begin
      ea = e - RLA;
      if (ea >= kill_before && rden_h[ea][r]) qa[r].push_back(model(NWA, SWA, SLA, RLA, ea, r));
      ea = e - RLB;
      if (ea >= kill_before && rden_h[ea][r]) qb[r].push_back(model(NWB, SWB, SLB, RLB, ea, r));
    end
  endtask

  task automatic do_reset();
    @(posedge aclk);
    #1;
    aresetn    = 1'b0;
    bus_a.rden = '0;
    bus_b.rden = '0;
    #1;
    chk("rst_a_rdvalid", bus_a.rdvalid, 0);
    chk("rst_a_rderr",   bus_a.rderr,   0);
    chk("rst_a_rddata",  bus_a.rddata,  0);
    chk("rst_b_rdvalid", bus_b.rdvalid, 0);
    chk("rst_b_rderr",   bus_b.rderr,   0);
    chk("rst_b_rddata",  bus_b.rddata,  0);
    kill_before = edge_cnt + 1;
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
  endtask

  task automatic mon_lane(input bit is_b, input int r);
    exp_t          x;
    bit            have;
    logic          v;
    logic          er;
    logic [DW-1:0] d;
    logic [DW-1:0] last;
    string         tag;
    tag  = is_b ? $sformatf("b%0d", r) : $sformatf("a%0d", r);
    v    = is_b ? bus_b.rdvalid[r] : bus_a.rdvalid[r];
    er   = is_b ? bus_b.rderr[r] : bus_a.rderr[r];
    d    = is_b ? bus_b.rddata[r*DW +: DW] : bus_a.rddata[r*DW +: DW];
    last = is_b ? last_b[r] : last_a[r];
    have = 1'b0;
    if (!is_b) begin
      while (qa[r].size() > 0 && qa[r][0].due < edge_cnt) begin
        x = qa[r].pop_front();
        checks++; errors++;
        $display("FAIL %s_missed got no rdvalid expected one at edge %0d", tag, x.due);
      end
      if (qa[r].size() > 0 && qa[r][0].due == edge_cnt) begin
        x = qa[r].pop_front();
        have = 1'b1;
      end
    end else begin
      while (qb[r].size() > 0 && qb[r][0].due < edge_cnt) begin
        x = qb[r].pop_front();
        checks++; errors++;
        $display("FAIL %s_missed got no rdvalid expected one at edge %0d", tag, x.due);
      end
      if (qb[r].size() > 0 && qb[r][0].due == edge_cnt) begin
        x = qb[r].pop_front();
        have = 1'b1;
      end
    end
    if (have) begin
      chk({tag, "_rdvalid"}, v, 1);
      chk({tag, "_rderr"}, er, x.err);
      chk({tag, "_rddata"}, d, x.data);
      if (is_b) last_b[r] = x.data;
      else      last_a[r] = x.data;
    end else begin
      chk({tag, "_idle_rdvalid"}, v, 0);
      chk({tag, "_idle_rderr"}, er, 0);
      chk({tag, "_hold_rddata"}, d, last);
    end
  endtask

  always @(negedge aclk) begin
    if (!aresetn) begin
      for (int r = 0; r < NR; r++) begin
        qa[r].delete();
        qb[r].delete();
        last_a[r] = '0;
        last_b[r] = '0;
      end
    end
    for (int r = 0; r < NR; r++) begin
      mon_lane(1'b0, r);
      mon_lane(1'b1, r);
    end
  end

  initial begin
    for (int i = 0; i < NCYC; i++) begin
      rden_h[i] = '0;
      for (int r = 0; r < NR; r++) begin
        sel_h[i][r] = '0;
        for (int w = 0; w < 3; w++) bank_h[i][w][r] = '0;
      end
    end
    bus_a.rden = '0; bus_a.rdselect = '0; bus_a.bank_rddata = '0;
    bus_b.rden = '0; bus_b.rdselect = '0; bus_b.bank_rddata = '0;
    repeat (3) @(posedge aclk);
    #1;
    chk("init_a_rdvalid", bus_a.rdvalid, 0);
    chk("init_a_rddata",  bus_a.rddata,  0);
    chk("init_b_rdvalid", bus_b.rdvalid, 0);
    chk("init_b_rddata",  bus_b.rddata,  0);
    aresetn = 1'b1;

    // single read on lane 0, select 1 one cycle later
    step(2'b01, 2'd0, 2'd0);
    step(2'b00, 2'd1, 2'd0);
    repeat (4) step(2'b00, 2'd0, 2'd0);
    // back-to-back on lane 1 with selects 0,1,1,0
    step(2'b10, 2'd0, 2'd0);
    step(2'b10, 2'd0, 2'd0);
    step(2'b10, 2'd0, 2'd1);
    step(2'b10, 2'd0, 2'd1);
    step(2'b00, 2'd0, 2'd0);
    repeat (4) step(2'b00, 2'd0, 2'd0);
    // both lanes in the same cycle, different banks
    step(2'b11, 2'd0, 2'd0);
    step(2'b00, 2'd0, 2'd1);
    repeat (4) step(2'b00, 2'd0, 2'd0);
    // out-of-range select, then an idle cycle
    step(2'b01, 2'd0, 2'd0);
    step(2'b00, 2'd3, 2'd3);
    repeat (5) step(2'b00, 2'd0, 2'd0);
    // reset while a read is in flight, then a normal read
    step(2'b01, 2'd0, 2'd0);
    step(2'b00, 2'd2, 2'd0);
    do_reset();
    step(2'b01, 2'd0, 2'd0);
    step(2'b00, 2'd1, 2'd0);
    repeat (5) step(2'b00, 2'd0, 2'd0);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) < 2) step(2'b00, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      else step(NR'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    end

    repeat (RLA + 3) step(2'b00, 2'd0, 2'd0);
    @(posedge aclk);
    #1;
    chk("drain_a", qa[0].size() + qa[1].size(), 0);
    chk("drain_b", qb[0].size() + qb[1].size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_read_collector.md
# mem_read_collector

Read-side output stage of the multi-agent RAM. One bank per write agent, each bank with one read port per read agent. For every read agent, this block tracks in-flight reads, aligns the memory-map accounter's select with the delayed bank data, and muxes the correct bank. It then returns registered read data with a valid strobe. It sits directly downstream of the accounter's per-agent `rdselect` output and the bank read ports.

## Interface
Parameters:
- DATA_WIDTH, 8: width of one read word.
- NB_WRAGENT, 2: number of write agents, which is also the number of banks.
- NB_RDAGENT, 2: number of read agents.
- SELECT_WIDTH, NB_WRAGENT==1 ? 1 : $clog2(NB_WRAGENT): width of one select field.
- SELECT_LATENCY, 1: cycles from `rden` to a valid `rdselect` for that read. Legal range is 0..RAM_LATENCY.
- RAM_LATENCY, 1: cycles from `rden` to valid bank data. Legal range is 1..8.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- aresetn  in  1  asynchronous active-low reset.
- rden  in  NB_RDAGENT  read request per agent, one cycle per read.
- rdselect  in  NB_RDAGENT*SELECT_WIDTH  bank index per agent, from the accounter; valid SELECT_LATENCY cycles after `rden`.
- bank_rddata  in  NB_WRAGENT*NB_RDAGENT*DATA_WIDTH  bank w, port r at `[(w*NB_RDAGENT+r)*DATA_WIDTH +: DATA_WIDTH]`.
- rddata  out  NB_RDAGENT*DATA_WIDTH  returned word, agent r at `[r*DATA_WIDTH +: DATA_WIDTH]`.
- rdvalid  out  NB_RDAGENT  one-cycle strobe per returned word.
- rderr  out  NB_RDAGENT  one-cycle strobe, issued alongside `rdvalid`, when the aligned select is >= NB_WRAGENT.

## Operation
Each read agent has a fully independent lane. There is no interaction between lanes.

Valid pipe:
- Each lane has a shift register of RAM_LATENCY bits.
- Stage 0 captures `rden[r]`; each stage shifts every cycle.

Select pipe:
- Each lane has a shift register of D = RAM_LATENCY-SELECT_LATENCY entries of SELECT_WIDTH bits.
- Stage 0 captures `rdselect[r]` every cycle, unconditionally.
- When D = 0, the live `rdselect[r]` is used directly as the aligned select.

Mux and output register, on the cycle where the valid pipe's last stage is set:
- Aligned select s < NB_WRAGENT: `rddata[r]` <= bank s, port r; `rdvalid[r]` <= 1; `rderr[r]` <= 0.
- s >= NB_WRAGENT (only possible when NB_WRAGENT is not a power of 2): `rddata[r]` <= 0; `rdvalid[r]` <= 1; `rderr[r]` <= 1.
- Otherwise: `rdvalid[r]` <= 0 and `rderr[r]` <= 0; `rddata[r]` holds its previous value.

Throughput and ordering:
- One read per lane per cycle.
- Back-to-back reads return in issue order with no bubbles.
- A read is never dropped except by reset.

Reset, asynchronous on `aresetn` low:
- Cleared: all valid pipes, all select pipes, `rddata`, `rdvalid`, `rderr`.
- In-flight reads are discarded and produce no `rdvalid` after release.
- The first `rden` sampled after release behaves like a normal read.

Boundary conditions:
- `rden` asserted while earlier reads are in flight: every read is pipelined independently.
- `rdselect` changing between reads: only the value at the aligned cycle matters.
- NB_WRAGENT = 1: the select is ignored for muxing; bank 0 is always chosen; `rderr` is never set.

## Timing
- Latency from `rden` (cycle t) to `rdvalid`/`rddata` is t+RAM_LATENCY+1 cycles. This is fixed and independent of SELECT_LATENCY.
- Bank data is sampled at edge t+RAM_LATENCY.
- `rdselect` is sampled at edge t+SELECT_LATENCY.
- All outputs are registered; there is no combinational path from any input to any output.
- Output reset values: `rddata` = 0, `rdvalid` = 0, `rderr` = 0.

## Test plan
- **Single read.** Config NB_WRAGENT=2, RAM_LATENCY=1, SELECT_LATENCY=1. Stimulus: `rden[0]` at t; `rdselect[0]`=1 at t+1; bank1 port0=0xA5 and bank0 port0=0x3C at t+1. Required: at t+2, `rdvalid[0]`=1, `rddata[0]`=0xA5, `rderr[0]`=0, `rdvalid[1]`=0.
- **Streaming, unequal latencies.** Config RAM_LATENCY=3, SELECT_LATENCY=1. Stimulus: `rden[1]` on 4 consecutive cycles with selects 0,1,1,0; banks return 0x10,0x21,0x22,0x13. Required: 4 consecutive `rdvalid[1]` starting at t+4, data 0x10,0x21,0x22,0x13 in order.
- **Lane independence.** Stimulus: `rden`=2'b11 at the same cycle, selects agent0=0 and agent1=1. Required: both lanes are valid on the same cycle, each with its own bank/port word.
- **Out-of-range select.** Config NB_WRAGENT=3, SELECT_WIDTH=2. Stimulus: a read with aligned select 3. Required: `rdvalid`=1, `rderr`=1, `rddata`=0; next cycle `rderr`=0.
- **Reset mid-flight.** Config RAM_LATENCY=4. Stimulus: `rden[0]` at t; `aresetn` low during t+2. Required: outputs are 0 immediately; no `rdvalid` follows. A new read after release returns at the normal latency.
- **Hold.** Stimulus: an idle gap after a read. Required: `rddata` keeps the last value while `rdvalid`=0.
